// File: rtl/fperm_lanes_pkg.sv
// Shared FP-cluster constants for the lane-permute unit: op encoding, ptype
// tags, single-precision field positions and the bias-derived seed constants.
package fperm_lanes_pkg;

  // Operation encoding
  localparam logic [2:0] OP_COPY_A  = 3'd0;
  localparam logic [2:0] OP_COPY_B  = 3'd1;
  localparam logic [2:0] OP_REVERSE = 3'd2;
  localparam logic [2:0] OP_BCAST   = 3'd3;
  localparam logic [2:0] OP_PERM    = 3'd4;
  localparam logic [2:0] OP_RCP_EST = 3'd5;
  localparam logic [2:0] OP_RSQ_EST = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  // Operand ptype tags carried in the top two bits of a vector
  localparam logic [1:0] PT_F32   = 2'd0;
  localparam logic [1:0] PT_F32V  = 2'd1;
  localparam logic [1:0] PT_INT   = 2'd2;
  localparam logic [1:0] PT_OTHER = 2'd3;

  // IEEE single field positions inside a lane
  localparam int unsigned SGN_BIT = 31;
  localparam int unsigned EXP_HI  = 30;
  localparam int unsigned EXP_LO  = 23;
  localparam int unsigned MAN_HI  = 22;

  // Bias-derived seed constants: 253 = 2*127-1, 380 = 3*127-1, 254 = max finite exp
  localparam int unsigned RCP_K     = 253;
  localparam int unsigned RSQ_K     = 380;
  localparam int unsigned EXP_MAXFN = 254;

endpackage

// File: rtl/fperm_lanes_if.sv
// Issue/result bus of the lane-permute unit.
//   master: producer/consumer side (drives in_valid, op, sel, a, b, out_ready)
//   slave : the permute unit (drives in_ready, out_valid, res, illegal, busy)
interface fperm_lanes_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 33
) ();
  localparam int unsigned DATA_W = 2 + LANES * LANE_W;
  localparam int unsigned SEL_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                op;
  logic [LANES*SEL_W-1:0]    sel;
  logic [DATA_W-1:0]         a;
  logic [DATA_W-1:0]         b;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         res;
  logic                      illegal;
  logic                      busy;

  modport master (
    output in_valid, op, sel, a, b, out_ready,
    input  in_ready, out_valid, res, illegal, busy
  );

  modport slave (
    input  in_valid, op, sel, a, b, out_ready,
    output in_ready, out_valid, res, illegal, busy
  );
endinterface

// File: rtl/fperm_lane_est.sv
// Single-lane reciprocal / reciprocal-sqrt exponent seed.
//   lane_i : one lane of operand B
//   rsq_i  : 1 selects the rsqrt seed, 0 the reciprocal seed
//   lane_o : seed lane (mantissa cleared, spare bit cleared unless passed through)
module fperm_lane_est
  import fperm_lanes_pkg::*;
#(
  parameter int unsigned LANE_W = 33
) (
  input  logic [LANE_W-1:0] lane_i,
  input  logic              rsq_i,
  output logic [LANE_W-1:0] lane_o
);

  logic [7:0] exp_in;
  logic       sgn_in;
  logic       man_nz;

  // Seed selection; exponent 255 (Inf/NaN) passes the lane through untouched
  always_comb begin
    exp_in = lane_i[EXP_HI:EXP_LO];
    sgn_in = lane_i[SGN_BIT];
    man_nz = |lane_i[MAN_HI:0];
    lane_o = '0;
    if (exp_in == 8'hFF) begin
      lane_o = lane_i;
    end else if (rsq_i) begin
      if (sgn_in && ((exp_in != 8'd0) || man_nz)) begin
        // Negative nonzero: canonical quiet NaN
        lane_o[EXP_HI:EXP_LO] = 8'hFF;
        lane_o[MAN_HI]        = 1'b1;
      end else if (exp_in == 8'd0) begin
        lane_o[EXP_HI:EXP_LO] = 8'(EXP_MAXFN);
      end else begin
        lane_o[EXP_HI:EXP_LO] = 8'((RSQ_K - 32'(exp_in)) >> 1);
      end
    end else begin
      lane_o[SGN_BIT] = sgn_in;
      if (exp_in == 8'd0) begin
        lane_o[EXP_HI:EXP_LO] = 8'(EXP_MAXFN);
      end else if (32'(exp_in) <= RCP_K) begin
        lane_o[EXP_HI:EXP_LO] = 8'(RCP_K - 32'(exp_in));
      end else begin
        lane_o[EXP_HI:EXP_LO] = 8'd0;
      end
    end
  end

endmodule

// File: rtl/fperm_lanes.sv
// Pipelined lane-permute unit: copy, reverse, broadcast, arbitrary permute and
// (with FPERM_LANES_EST_EN defined) per-lane rcp/rsqrt exponent seeds.
// Results leave through a LAT-stage global-stall valid/ready pipeline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fperm_lanes_if slave (in_valid/in_ready, op, sel, a, b,
//              out_valid/out_ready, res, illegal, busy)
// Macro FPERM_LANES_EST_EN: when undefined, ops 5/6 act as reserved ops.
module fperm_lanes
  import fperm_lanes_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 33,
  parameter int unsigned LAT    = 2
) (
  input  logic           clk,
  input  logic           rst,
  fperm_lanes_if.slave   bus
);

  localparam int unsigned DATA_W = 2 + LANES * LANE_W;
  localparam int unsigned SEL_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANE_W-1:0] a_lane [LANES];
  logic [DATA_W-1:0] res_d;
  logic              ill_d;

  logic              vld_q [LAT];
  logic              ill_q [LAT];
  logic [DATA_W-1:0] dat_q [LAT];
  logic              stall;
  logic              busy_c;

  // Split operand A into lanes for the permute muxes
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      a_lane[i] = bus.a[i*LANE_W +: LANE_W];
    end
  end

`ifdef FPERM_LANES_EST_EN
  logic [LANE_W-1:0] est_lane [LANES];
  logic              est_rsq;

  assign est_rsq = (bus.op == OP_RSQ_EST);

  for (genvar g = 0; g < LANES; g++) begin : g_est
    fperm_lane_est #(
      .LANE_W (LANE_W)
    ) u_est (
      .lane_i (bus.b[g*LANE_W +: LANE_W]),
      .rsq_i  (est_rsq),
      .lane_o (est_lane[g])
    );
  end
`endif

  // Stage-0 result and illegal flag
  always_comb begin
    res_d = '0;
    ill_d = 1'b0;
    case (bus.op)
      OP_COPY_A: res_d = bus.a;
      OP_COPY_B: res_d = bus.b;
      OP_REVERSE: begin
        res_d[DATA_W-1 -: 2] = bus.a[DATA_W-1 -: 2];
        for (int unsigned i = 0; i < LANES; i++) begin
          res_d[i*LANE_W +: LANE_W] = a_lane[LANES-1-i];
        end
      end
      OP_BCAST: begin
        res_d[DATA_W-1 -: 2] = bus.a[DATA_W-1 -: 2];
        for (int unsigned i = 0; i < LANES; i++) begin
          res_d[i*LANE_W +: LANE_W] = a_lane[bus.sel[SEL_W-1:0]];
        end
      end
      OP_PERM: begin
        res_d[DATA_W-1 -: 2] = bus.a[DATA_W-1 -: 2];
        for (int unsigned i = 0; i < LANES; i++) begin
          res_d[i*LANE_W +: LANE_W] = a_lane[bus.sel[i*SEL_W +: SEL_W]];
        end
      end
      OP_RCP_EST, OP_RSQ_EST: begin
`ifdef FPERM_LANES_EST_EN
        res_d[DATA_W-1 -: 2] = bus.b[DATA_W-1 -: 2];
        for (int unsigned i = 0; i < LANES; i++) begin
          res_d[i*LANE_W +: LANE_W] = est_lane[i];
        end
`else
        res_d = bus.b;
        ill_d = 1'b1;
`endif
      end
      default: begin
        res_d = bus.b;
        ill_d = 1'b1;
      end
    endcase
  end

  // Global stall: the whole pipe freezes while the head result is refused
  assign stall        = vld_q[LAT-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Stage valid bits (the only reset state)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      vld_q[0] <= bus.in_valid;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Stage payloads, no reset needed; qualified by vld_q at the output
  always_ff @(posedge clk) begin
    if (!stall) begin
      dat_q[0] <= res_d;
      ill_q[0] <= ill_d;
      for (int unsigned i = 1; i < LAT; i++) begin
        dat_q[i] <= dat_q[i-1];
        ill_q[i] <= ill_q[i-1];
      end
    end
  end

  // Occupancy
  always_comb begin
    busy_c = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      busy_c = busy_c | vld_q[i];
    end
  end

  assign bus.out_valid = vld_q[LAT-1];
  assign bus.res       = vld_q[LAT-1] ? dat_q[LAT-1] : '0;
  assign bus.illegal   = vld_q[LAT-1] & ill_q[LAT-1];
  assign bus.busy      = busy_c;

endmodule
